// File: rtl/pipe_out_pkg.sv
// Shared types and defaults for the host block-pipe-out controller.
package pipe_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_GUARD = 2'd2
  } pipe_state_t;

  localparam int unsigned PIPE_BLOCK_WORDS_DEF = 128;
  localparam logic [31:0] PIPE_PAD_WORD_DEF    = 32'hDEAD_BEEF;
  localparam int unsigned PIPE_STAT_W          = 16;

endpackage

// File: rtl/pipe_out_block_ctrl.sv
// Block-throttle controller between the 64-to-32 output FIFO and the host pipe-out.
// Optional statistics counters are built when PIPE_OUT_STATS_EN is defined.
module pipe_out_block_ctrl
  import pipe_out_pkg::*;
#(
  parameter int unsigned       BLOCK_WORDS = PIPE_BLOCK_WORDS_DEF,
  parameter int unsigned       CNT_W       = 10,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [DATA_W-1:0] PAD_WORD    = DATA_W'(PIPE_PAD_WORD_DEF),
  parameter int unsigned       GUARD       = 2
) (
  input  logic                   okClk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      fifo_dout,
  input  logic                   fifo_valid,
  input  logic                   fifo_empty,
  input  logic [CNT_W-1:0]       fifo_rd_count,
  output logic                   fifo_rd_en,
  input  logic                   pipe_out_read,
  output logic                   pipe_out_ready,
  output logic [DATA_W-1:0]      pipe_out_data,
  output logic                   blk_done,
  output logic                   underrun,
  input  logic                   stat_clr,
  output logic [PIPE_STAT_W-1:0] blk_count,
  output logic [PIPE_STAT_W-1:0] urun_count
);

  localparam int unsigned WC_W = $clog2(BLOCK_WORDS + 1);
  localparam int unsigned GC_W = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [WC_W-1:0]  BLK_LAST = WC_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] BLK_THR  = CNT_W'(BLOCK_WORDS);

  pipe_state_t       state, state_next;
  logic [WC_W-1:0]   word_cnt, word_cnt_next;
  logic [GC_W-1:0]   guard_cnt, guard_cnt_next;
  logic              blk_end;
  logic              permit;
  logic              urun_c;
  logic              rd_q, en_q;
  logic [DATA_W-1:0] data_hold;

  // State register
  always_ff @(posedge okClk) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      guard_cnt <= '0;
    end else begin
      state     <= state_next;
      word_cnt  <= word_cnt_next;
      guard_cnt <= guard_cnt_next;
    end
  end

  // Next-state logic; underrun strobes still advance the word count
  always_comb begin
    state_next     = state;
    word_cnt_next  = word_cnt;
    guard_cnt_next = guard_cnt;
    blk_end        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pipe_out_read && pipe_out_ready) begin
          word_cnt_next = WC_W'(1);
          if (BLK_LAST == WC_W'(1)) begin
            blk_end        = 1'b1;
            guard_cnt_next = '0;
            state_next     = ST_GUARD;
          end else begin
            state_next = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (pipe_out_read) begin
          word_cnt_next = word_cnt + WC_W'(1);
          if (word_cnt == BLK_LAST - WC_W'(1)) begin
            blk_end        = 1'b1;
            guard_cnt_next = '0;
            state_next     = ST_GUARD;
          end
        end
      end
      ST_GUARD: begin
        if (32'(guard_cnt) + 32'd1 >= 32'(GUARD)) begin
          state_next = ST_IDLE;
        end else begin
          guard_cnt_next = guard_cnt + GC_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: FIFO read enable and one-cycle data return
  always_comb begin
    permit = 1'b0;
    case (state)
      ST_IDLE: permit = pipe_out_ready;
      ST_XFER: permit = 1'b1;
      default: permit = 1'b0;
    endcase
    fifo_rd_en    = pipe_out_read & ~fifo_empty & permit;
    urun_c        = rd_q & ~(en_q & fifo_valid);
    pipe_out_data = data_hold;
    if (rd_q) begin
      pipe_out_data = (en_q & fifo_valid) ? fifo_dout : PAD_WORD;
    end
  end

  // Readiness, data pipeline and sticky underrun
  always_ff @(posedge okClk) begin
    if (reset) begin
      pipe_out_ready <= 1'b0;
      blk_done       <= 1'b0;
      rd_q           <= 1'b0;
      en_q           <= 1'b0;
      data_hold      <= '0;
      underrun       <= 1'b0;
    end else begin
      pipe_out_ready <= (state_next == ST_IDLE) && (fifo_rd_count >= BLK_THR);
      blk_done       <= blk_end;
      rd_q           <= pipe_out_read;
      en_q           <= fifo_rd_en;
      if (rd_q) begin
        data_hold <= pipe_out_data;
      end
      if (stat_clr) begin
        underrun <= 1'b0;
      end else if (urun_c) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef PIPE_OUT_STATS_EN
  logic [PIPE_STAT_W-1:0] blk_cnt_q, urun_cnt_q;

  // Block count wraps, underrun count saturates
  always_ff @(posedge okClk) begin
    if (reset || stat_clr) begin
      blk_cnt_q  <= '0;
      urun_cnt_q <= '0;
    end else begin
      if (blk_done) begin
        blk_cnt_q <= blk_cnt_q + PIPE_STAT_W'(1);
      end
      if (urun_c && (urun_cnt_q != '1)) begin
        urun_cnt_q <= urun_cnt_q + PIPE_STAT_W'(1);
      end
    end
  end

  assign blk_count  = blk_cnt_q;
  assign urun_count = urun_cnt_q;
`else
  assign blk_count  = '0;
  assign urun_count = '0;
`endif

endmodule

// File: tb/tb_pipe_out_block_ctrl.sv
// Randomized scoreboard bench for pipe_out_block_ctrl with a behavioural FIFO and controller model.
module tb_pipe_out_block_ctrl;

  localparam int unsigned BW    = 128;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned GUARD = 2;
  localparam logic [31:0] PAD   = 32'hDEAD_BEEF;
`ifdef PIPE_OUT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             okClk = 1'b0;
  logic             reset = 1'b1;
  logic [DW-1:0]    fifo_dout = '0;
  logic             fifo_valid = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [CNT_W-1:0] fifo_rd_count = '0;
  logic             fifo_rd_en;
  logic             pipe_out_read = 1'b0;
  logic             pipe_out_ready;
  logic [DW-1:0]    pipe_out_data;
  logic             blk_done;
  logic             underrun;
  logic             stat_clr = 1'b0;
  logic [15:0]      blk_count;
  logic [15:0]      urun_count;

  pipe_out_block_ctrl dut (
    .okClk(okClk), .reset(reset),
    .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
    .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en),
    .pipe_out_read(pipe_out_read), .pipe_out_ready(pipe_out_ready),
    .pipe_out_data(pipe_out_data), .blk_done(blk_done), .underrun(underrun),
    .stat_clr(stat_clr), .blk_count(blk_count), .urun_count(urun_count)
  );

  always #5 okClk = ~okClk;

  int checks = 0;
  int errors = 0;
  logic [31:0] fq[$];
  logic [31:0] sb[$];
  logic [31:0] next_word = 32'd0;
  bit mon_cap;

  // Reference controller state (block progress, guard time left, flags, statistics)
  bit m_active, m_ready, m_done, m_urun, m_pend;
  int m_words, m_guard, m_bcnt, m_ucnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: registered count/empty, data valid the cycle after a read
  always @(posedge okClk) begin
    if (reset) begin
      fq.delete();
      fifo_valid <= 1'b0;
      fifo_dout  <= '0;
    end else if (fifo_rd_en && fq.size() > 0) begin
      fifo_dout  <= fq.pop_front();
      fifo_valid <= 1'b1;
    end else begin
      fifo_valid <= 1'b0;
    end
    fifo_rd_count <= CNT_W'(fq.size());
    fifo_empty    <= (fq.size() == 0);
  end

  // Monitor: every strobe presents one word in the following cycle
  initial forever begin
    @(posedge okClk);
    mon_cap = pipe_out_read && !reset;
    #1;
    if (mon_cap) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data: unexpected word %h at %0t", pipe_out_data, $time);
      end else begin
        chk("data", pipe_out_data, sb.pop_front());
      end
    end
  end

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      next_word++;
    end
  endtask

  // One clock cycle: compare registered outputs, drive inputs, advance the model
  task automatic step(input bit rd, input bit clr = 1'b0, input bit rst = 1'b0);
    bit idle, start, en, v, ev;
    chk("ready", pipe_out_ready, m_ready);
    chk("blk_done", blk_done, m_done);
    chk("underrun", underrun, m_urun);
    chk("blk_count", blk_count, STATS ? m_bcnt : 0);
    chk("urun_count", urun_count, STATS ? m_ucnt : 0);
    pipe_out_read = rd;
    stat_clr      = clr;
    reset         = rst;
    #1;
    idle  = !m_active && (m_guard == 0);
    start = idle && m_ready && rd;
    en    = rd && (start || m_active) && !fifo_empty;
    if (!rst) chk("fifo_rd_en", fifo_rd_en, en);
    ev = m_pend;
    if (rst) begin
      m_active = 0; m_ready = 0; m_done = 0; m_urun = 0; m_pend = 0;
      m_words = 0; m_guard = 0; m_bcnt = 0; m_ucnt = 0;
      sb.delete();
    end else begin
      m_pend = 1'b0;
      if (rd) begin
        v = en && (fq.size() > 0);
        sb.push_back(v ? fq[0] : PAD);
        m_pend = !v;
      end
      if (clr) begin
        m_urun = 0; m_ucnt = 0; m_bcnt = 0;
      end else begin
        if (ev) begin
          m_urun = 1;
          if (m_ucnt < 65535) m_ucnt++;
        end
        if (m_done) m_bcnt = (m_bcnt + 1) & 16'hFFFF;
      end
      m_done = 0;
      if (start || (m_active && rd)) begin
        m_words  = start ? 1 : m_words + 1;
        m_active = 1;
        if (m_words == BW) begin
          m_active = 0;
          m_guard  = GUARD;
          m_done   = 1;
        end
      end else if (m_guard > 0) begin
        m_guard--;
      end
      m_ready = !m_active && (m_guard == 0) && (fifo_rd_count >= BW);
    end
    @(negedge okClk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!m_ready && n < 400) begin
      step(1'b0);
      n++;
    end
    if (!m_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: ready not expected within %0d cycles", n);
    end
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  int gap;

  initial begin
    m_active = 0; m_ready = 0; m_done = 0; m_urun = 0; m_pend = 0;
    m_words = 0; m_guard = 0; m_bcnt = 0; m_ucnt = 0;
    repeat (3) @(posedge okClk);
    @(negedge okClk);
    step(1'b0, 1'b0, 1'b1);
    chk("reset_data", pipe_out_data, 32'd0);
    chk("reset_ready", pipe_out_ready, 1'b0);

    // Full clean block of words 0..127
    push(128);
    wait_ready();
    strobes(128);
    idles(4);
    chk("blk1_count", blk_count, STATS ? 1 : 0);
    chk("blk1_underrun", underrun, 1'b0);

    // 127 words buffered: not ready, strobe gives the pad word
    push(127);
    idles(4);
    chk("ready_127", pipe_out_ready, 1'b0);
    step(1'b1);
    idles(2);
    chk("idle_underrun", underrun, 1'b1);
    step(1'b0, 1'b1);

    // FIFO empties after 100 words of a block
    push(1);
    wait_ready();
    strobes(100);
    fq.delete();
    strobes(28);
    idles(4);
    chk("stall_urun_count", urun_count, STATS ? 28 : 0);
    chk("stall_blk_count", blk_count, STATS ? 1 : 0);

    // Two back-to-back blocks with the guard gap measured
    step(1'b0, 1'b1);
    push(256);
    wait_ready();
    strobes(128);
    gap = 1;
    while (!pipe_out_ready && gap < 50) begin
      step(1'b0);
      gap++;
    end
    chk("guard_gap", gap, GUARD + 1);
    strobes(128);
    idles(4);
    chk("b2b_blk_count", blk_count, STATS ? 2 : 0);
    chk("b2b_underrun", underrun, 1'b0);

    // Reset after strobe 50, then a clean block
    step(1'b0, 1'b1);
    push(128);
    wait_ready();
    strobes(50);
    step(1'b0, 1'b0, 1'b1);
    chk("mid_rst_data", pipe_out_data, 32'd0);
    chk("mid_rst_ready", pipe_out_ready, 1'b0);
    chk("mid_rst_underrun", underrun, 1'b0);
    push(128);
    wait_ready();
    strobes(128);
    idles(4);
    chk("post_rst_blk_count", blk_count, STATS ? 1 : 0);
    chk("post_rst_underrun", underrun, 1'b0);

    // stat_clr in the cycle the underrun would be recorded
    step(1'b1);
    step(1'b0, 1'b1);
    step(1'b0);
    chk("clr_underrun", underrun, 1'b0);
    chk("clr_urun_count", urun_count, 16'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0 && fq.size() < 700) push($urandom_range(1, 64));
      if ($urandom_range(0, 299) == 0) fq.delete();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0, $urandom_range(0, 799) == 0);
    end
    idles(4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
